astable_ctrl: RTL and testbench
===============================

# astable_ctrl

Programmable astable-multivibrator controller for the tt_um_SophusAndreassen_astabilmultivibator top. It generates a square wave with register-programmed high and low phase lengths, counted in clock cycles. It runs either continuously or for a programmed burst of periods. Configuration writes come from the top-level pins through a simple write strobe, and start/stop pulses sequence the oscillator.

## Interface
- W, 8, width of the phase-length registers, phase counter and burst register.
- clk  input  1  system clock; every event is on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- ena  input  1  enable; when 0, state, counters and outputs hold.
- cfg_data  input  W  configuration write data.
- cfg_addr  input  2  register select:
  - 0 = HIGH_LEN
  - 1 = LOW_LEN
  - 2 = BURST
  - 3 = ignored
- cfg_we  input  1  write strobe; one write per cycle while high.
- start  input  1  launch request; sampled only in IDLE.
- stop  input  1  abort request; honoured in any state.
- osc_out  output  1  oscillator output; registered.
- busy  output  1  1 when the state is HIGH or LOW.
- burst_done  output  1  one-cycle pulse when a burst completes.
- period_cnt  output  8  completed periods since the last start; wraps modulo 256.

## Operation
- Reset (rst_n=0 at an edge) sets:
  - state=IDLE
  - HIGH_LEN=1, LOW_LEN=1, BURST=0
  - counter=0
  - osc_out=0, busy=0, burst_done=0, period_cnt=0
- Reset takes priority over every other input, ena included.
- Register writes:
  - Accepted in any state whenever cfg_we=1 and ena=1.
  - HIGH_LEN and LOW_LEN are read live at each phase load. A write during a run takes effect at the next load of that phase and never shortens the current phase.
  - BURST is copied into a burst latch at start. Writes to BURST during a run do not affect that run.
- Phase length: a value of 0 is treated as 1. A value of N gives exactly N cycles.
- States:
  - IDLE:
    - osc_out=0.
    - start=1 with stop=0: load counter with eff(HIGH_LEN), latch BURST, clear period_cnt, go to HIGH.
  - HIGH:
    - osc_out=1.
    - Counter decrements each enabled cycle.
    - On the cycle the counter is 1: load eff(LOW_LEN) and go to LOW.
  - LOW:
    - osc_out=0.
    - On the cycle the counter is 1, increment period_cnt.
    - If the burst latch is nonzero and the new period_cnt equals the latch: go to IDLE and set burst_done=1 for one cycle.
    - Otherwise: load eff(HIGH_LEN) and go to HIGH.
- BURST=0 means continuous operation until stop.
- stop=1 (with ena=1):
  - Next state is IDLE, osc_out=0.
  - No burst_done pulse; period_cnt holds its value.
  - stop wins over a simultaneous start.
- start while busy is ignored. It does not restart or extend the run.
- ena=0 freezes everything, including cfg writes and start/stop sampling. burst_done, if high, stays high until the next enabled cycle.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Start latency: start sampled at edge t gives osc_out=1 and busy=1 after edge t+1.
- With H=eff(HIGH_LEN), L=eff(LOW_LEN) and ena held high:
  - osc_out is high for cycles t+1 … t+H.
  - osc_out is low for cycles t+H+1 … t+H+L.
  - The period is H+L cycles and the duty cycle is H/(H+L).
- Burst of B periods:
  - The last LOW cycle is t+B(H+L).
  - After the edge at the end of that cycle: state=IDLE, busy=0, burst_done=1 for one cycle.
  - A start sampled during the burst_done cycle is accepted, since the state is already IDLE.
- Stop latency: stop sampled at edge s gives osc_out=0 and busy=0 after edge s+1.
- period_cnt updates on the same edge that leaves a LOW phase.
- Minimum period: 2 cycles (H=L=1, including the 0→1 rule).
- A config write at edge w is visible to a phase load at edge w+1 or later.

## Test plan
- Reset defaults: hold rst_n=0 for 2 cycles with start=1 → osc_out=0, busy=0, period_cnt=0, burst_done=0. Then start with the default registers → square wave with period 2 (1 high, 1 low).
- Programmed wave: write HIGH_LEN=3, LOW_LEN=5, BURST=0, then start.
  - Required: 3 high / 5 low repeating.
  - Required: period_cnt counts 1, 2, 3, … and wraps 255→0.
  - Required: busy stays 1 until stop.
- Burst: HIGH_LEN=2, LOW_LEN=2, BURST=4, start at t.
  - Required: exactly 4 periods.
  - Required: burst_done=1 only in cycle t+17.
  - Required: busy falls at the same cycle; period_cnt=4.
- Stop and precedence:
  - stop mid-HIGH → osc_out=0 next cycle, no burst_done.
  - start+stop in the same cycle in IDLE → stays IDLE.
  - start during a run → waveform unchanged.
- Live update: during a run with H=4, write HIGH_LEN=1 mid-HIGH → the current high phase still lasts 4 cycles and the next high phase lasts 1. Write HIGH_LEN=0 → high phases last 1 cycle.
- Enable freeze: drop ena for 3 cycles mid-LOW → osc_out, the counter and period_cnt hold, and the LOW phase is stretched by exactly 3 cycles.

Source files
------------

// File: rtl/astable_ctrl_if.sv
// Configuration, sequencing and status bundle of the astable oscillator controller.
// The master drives configuration and start/stop; the slave returns registered status.
interface astable_ctrl_if #(parameter int W = 8);
    logic         ena;
    logic [W-1:0] cfg_data;
    logic [1:0]   cfg_addr;
    logic         cfg_we;
    logic         start;
    logic         stop;
    logic         osc_out;
    logic         busy;
    logic         burst_done;
    logic [7:0]   period_cnt;

    modport master (
        output ena, cfg_data, cfg_addr, cfg_we, start, stop,
        input  osc_out, busy, burst_done, period_cnt
    );

    modport slave (
        input  ena, cfg_data, cfg_addr, cfg_we, start, stop,
        output osc_out, busy, burst_done, period_cnt
    );
endinterface

// File: rtl/astable_ctrl.sv
// Programmable square-wave generator with continuous or burst mode; all outputs registered,
// one edge from start/stop to output; no backpressure, ena=0 freezes the whole block.
module astable_ctrl #(
    parameter int W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    astable_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t       state_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] high_len_q;
    logic [W-1:0] low_len_q;
    logic [W-1:0] burst_q;
    logic [W-1:0] burst_lat_q;
    logic         osc_q;
    logic         busy_q;
    logic         done_q;
    logic [7:0]   pcnt_q;

    logic [W-1:0] high_eff_d;
    logic [W-1:0] low_eff_d;
    logic [7:0]   pcnt_d;

    // A programmed length of zero still yields a one-cycle phase.
    assign high_eff_d = (high_len_q == '0) ? W'(1) : high_len_q;
    assign low_eff_d  = (low_len_q  == '0) ? W'(1) : low_len_q;
    assign pcnt_d     = pcnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_len_q  <= W'(1);
            low_len_q   <= W'(1);
            burst_q     <= '0;
            burst_lat_q <= '0;
            osc_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pcnt_q      <= 8'd0;
        end else if (bus.ena) begin
            done_q <= 1'b0;
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0:    high_len_q <= bus.cfg_data;
                    2'd1:    low_len_q  <= bus.cfg_data;
                    2'd2:    burst_q    <= bus.cfg_data;
                    default: ;
                endcase
            end
            if (bus.stop) begin
                state_q <= IDLE;
                osc_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            cnt_q       <= high_eff_d;
                            burst_lat_q <= burst_q;
                            pcnt_q      <= 8'd0;
                            state_q     <= HIGH;
                            osc_q       <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt_q == W'(1)) begin
                            cnt_q   <= low_eff_d;
                            state_q <= LOW;
                            osc_q   <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - W'(1);
                        end
                    end
                    LOW: begin
                        if (cnt_q == W'(1)) begin
                            pcnt_q <= pcnt_d;
                            if (burst_lat_q != '0 && W'(pcnt_d) == burst_lat_q) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                cnt_q   <= high_eff_d;
                                state_q <= HIGH;
                                osc_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        osc_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.osc_out    = osc_q;
    assign bus.busy       = busy_q;
    assign bus.burst_done = done_q;
    assign bus.period_cnt = pcnt_q;
endmodule

// File: tb/tb_astable_ctrl.sv
// Directed scenarios with hand-derived waveforms plus a randomized run checked
// cycle by cycle against a phase-length reference model.
module tb_astable_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    astable_ctrl_if #(.W(8)) bus ();

    astable_ctrl #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a run is a sequence of phases whose length is fixed when the phase begins.
    int m_hi_len = 1, m_lo_len = 1, m_burst = 0;
    bit m_run = 0, m_phase_hi = 0, m_done = 0;
    int m_elapsed = 0, m_plen = 0, m_target = 0, m_periods = 0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_step();
        int hl, ll;
        if (!rst_n) begin
            m_hi_len = 1; m_lo_len = 1; m_burst = 0;
            m_run = 0; m_phase_hi = 0; m_done = 0;
            m_elapsed = 0; m_plen = 0; m_target = 0; m_periods = 0;
        end else if (bus.ena) begin
            hl = eff(m_hi_len);
            ll = eff(m_lo_len);
            m_done = 0;
            if (bus.stop) begin
                m_run = 0;
            end else if (!m_run) begin
                if (bus.start) begin
                    m_run = 1; m_phase_hi = 1; m_elapsed = 0; m_plen = hl;
                    m_target = m_burst; m_periods = 0;
                end
            end else begin
                m_elapsed++;
                if (m_elapsed == m_plen) begin
                    m_elapsed = 0;
                    if (m_phase_hi) begin
                        m_phase_hi = 0; m_plen = ll;
                    end else begin
                        m_periods = (m_periods + 1) % 256;
                        if (m_target != 0 && m_periods == m_target) begin
                            m_run = 0; m_done = 1;
                        end else begin
                            m_phase_hi = 1; m_plen = hl;
                        end
                    end
                end
            end
            if (bus.cfg_we) begin
                case (bus.cfg_addr)
                    2'd0: m_hi_len = int'(bus.cfg_data);
                    2'd1: m_lo_len = int'(bus.cfg_data);
                    2'd2: m_burst  = int'(bus.cfg_data);
                    default: ;
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1; tick(); bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b1;
        tick(); tick();
        n_tests++; if (bus.osc_out !== 1'b0) begin n_fail++; $display("FAIL reset_osc: got %b want 0", bus.osc_out); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.period_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_pcnt: got %0d want 0", bus.period_cnt); end
        n_tests++; if (bus.burst_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.burst_done); end
        rst_n = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (bus.osc_out !== ((i % 2) == 0)) begin
                n_fail++; $display("FAIL default_wave cycle %0d: got %b want %b", i, bus.osc_out, (i % 2) == 0);
                break;
            end
            tick();
        end
        do_stop();
    endtask

    task automatic test_programmed();
        bit bad = 0;
        wr(2'd0, 8'd3); wr(2'd1, 8'd5); wr(2'd2, 8'd0);
        do_start();
        for (int i = 0; i < 2064 && !bad; i++) begin
            n_tests++;
            if (bus.osc_out !== ((i % 8) < 3)) begin
                n_fail++; bad = 1; $display("FAIL prog_wave cycle %0d: got %b want %b", i, bus.osc_out, (i % 8) < 3);
            end
            n_tests++;
            if (bus.period_cnt !== 8'((i / 8) % 256)) begin
                n_fail++; bad = 1; $display("FAIL prog_pcnt cycle %0d: got %0d want %0d", i, bus.period_cnt, (i / 8) % 256);
            end
            n_tests++;
            if (bus.busy !== 1'b1) begin
                n_fail++; bad = 1; $display("FAIL prog_busy cycle %0d: got %b want 1", i, bus.busy);
            end
            tick();
        end
        do_stop();
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL prog_stop_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.period_cnt !== 8'd2) begin n_fail++; $display("FAIL prog_stop_pcnt: got %0d want 2", bus.period_cnt); end
    endtask

    task automatic test_burst();
        bit bad = 0;
        wr(2'd0, 8'd2); wr(2'd1, 8'd2); wr(2'd2, 8'd4);
        do_start();
        for (int i = 1; i <= 20 && !bad; i++) begin
            n_tests++;
            if (bus.burst_done !== (i == 17)) begin
                n_fail++; bad = 1; $display("FAIL burst_done cycle t+%0d: got %b want %b", i, bus.burst_done, i == 17);
            end
            n_tests++;
            if (bus.busy !== (i <= 16)) begin
                n_fail++; bad = 1; $display("FAIL burst_busy cycle t+%0d: got %b want %b", i, bus.busy, i <= 16);
            end
            n_tests++;
            if (bus.osc_out !== (i <= 16 && ((i - 1) % 4) < 2)) begin
                n_fail++; bad = 1; $display("FAIL burst_wave cycle t+%0d: got %b", i, bus.osc_out);
            end
            if (i == 17) begin
                n_tests++;
                if (bus.period_cnt !== 8'd4) begin
                    n_fail++; $display("FAIL burst_pcnt: got %0d want 4", bus.period_cnt);
                end
            end
            tick();
        end
        // One-period burst with ena dropped while burst_done is high.
        wr(2'd0, 8'd1); wr(2'd1, 8'd1); wr(2'd2, 8'd1);
        do_start();
        tick(); tick();
        n_tests++; if (bus.burst_done !== 1'b1) begin n_fail++; $display("FAIL hold_done_t3: got %b want 1", bus.burst_done); end
        bus.ena = 1'b0;
        tick();
        n_tests++; if (bus.burst_done !== 1'b1) begin n_fail++; $display("FAIL hold_done_t4: got %b want 1", bus.burst_done); end
        tick();
        n_tests++; if (bus.burst_done !== 1'b1) begin n_fail++; $display("FAIL hold_done_t5: got %b want 1", bus.burst_done); end
        bus.ena = 1'b1;
        tick();
        n_tests++; if (bus.burst_done !== 1'b0) begin n_fail++; $display("FAIL hold_done_t6: got %b want 0", bus.burst_done); end
        wr(2'd2, 8'd0);
    endtask

    task automatic test_stop();
        bit bad = 0;
        wr(2'd0, 8'd5); wr(2'd1, 8'd3);
        do_start();
        tick(); tick();
        do_stop();
        n_tests++; if (bus.osc_out !== 1'b0) begin n_fail++; $display("FAIL stop_osc: got %b want 0", bus.osc_out); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b want 0", bus.busy); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (bus.burst_done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL stop_quiet cycle %0d: done %b busy %b want 0 0", i, bus.burst_done, bus.busy);
            end
            tick();
        end
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_stop_busy: got %b want 0", bus.busy); end
        n_tests++; if (bus.osc_out !== 1'b0) begin n_fail++; $display("FAIL start_stop_osc: got %b want 0", bus.osc_out); end
        do_start();
        for (int i = 0; i < 24 && !bad; i++) begin
            n_tests++;
            if (bus.osc_out !== ((i % 8) < 5) || bus.busy !== 1'b1) begin
                n_fail++; bad = 1;
                $display("FAIL restart_ignored cycle %0d: osc %b busy %b want %b 1", i, bus.osc_out, bus.busy, (i % 8) < 5);
            end
            if (i == 3 || i == 12) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        do_stop();
    endtask

    task automatic test_live_update();
        logic [12:0] pat = 13'b1001001001111;
        int run = 0, maxrun = 0, highs = 0;
        wr(2'd0, 8'd4); wr(2'd1, 8'd2);
        do_start();
        for (int i = 0; i <= 12; i++) begin
            n_tests++;
            if (bus.osc_out !== pat[i]) begin
                n_fail++; $display("FAIL live_high cycle %0d: got %b want %b", i, bus.osc_out, pat[i]);
                break;
            end
            if (i == 1) begin bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd1; end
            tick();
            bus.cfg_we = 1'b0;
        end
        wr(2'd0, 8'd0);
        tick(); tick(); tick();
        for (int i = 0; i < 12; i++) begin
            if (bus.osc_out === 1'b1) begin
                run++; highs++;
                if (run > maxrun) maxrun = run;
            end else begin
                run = 0;
            end
            tick();
        end
        n_tests++; if (maxrun != 1) begin n_fail++; $display("FAIL live_zero_len: longest high %0d want 1", maxrun); end
        n_tests++; if (highs != 4) begin n_fail++; $display("FAIL live_zero_count: highs %0d want 4", highs); end
        do_stop();
    endtask

    task automatic test_ena_freeze();
        wr(2'd0, 8'd2); wr(2'd1, 8'd4);
        do_start();
        for (int i = 0; i < 12; i++) begin
            n_tests++;
            if (bus.osc_out !== (i < 2 || (i >= 9 && i < 11))) begin
                n_fail++; $display("FAIL freeze_wave cycle %0d: got %b", i, bus.osc_out);
                break;
            end
            n_tests++;
            if (bus.period_cnt !== ((i >= 9) ? 8'd1 : 8'd0)) begin
                n_fail++; $display("FAIL freeze_pcnt cycle %0d: got %0d", i, bus.period_cnt);
                break;
            end
            bus.ena = (i >= 3 && i <= 5) ? 1'b0 : 1'b1;
            tick();
        end
        bus.ena = 1'b1;
        do_stop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n        = ($urandom_range(0, 499) != 0);
            bus.ena      = ($urandom_range(0, 9) != 0);
            bus.cfg_we   = ($urandom_range(0, 4) == 0);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            bus.cfg_data = 8'($urandom_range(0, 5));
            bus.start    = ($urandom_range(0, 9) == 0);
            bus.stop     = ($urandom_range(0, 49) == 0);
            tick();
            n_tests++;
            if (bus.osc_out !== (m_run && m_phase_hi) || bus.busy !== m_run ||
                bus.burst_done !== m_done || bus.period_cnt !== 8'(m_periods)) begin
                n_fail++;
                $display("FAIL random cycle %0d: osc %b busy %b done %b pcnt %0d want %b %b %b %0d",
                         i, bus.osc_out, bus.busy, bus.burst_done, bus.period_cnt,
                         m_run && m_phase_hi, m_run, m_done, m_periods);
                break;
            end
        end
        rst_n = 1'b1; bus.ena = 1'b1; bus.cfg_we = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.ena = 1'b1; bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_data = 8'd0;
        bus.start = 1'b0; bus.stop = 1'b0;
        test_reset();
        test_programmed();
        test_burst();
        test_stop();
        test_live_update();
        test_ena_freeze();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
